// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF sequencer.
package ro_puf_pkg;

    localparam int CHAL_W = 2;
    localparam int CNT_W  = 4;
    localparam int RESP_W = 4;
    localparam int VOTE_W = 4;

    localparam int VOTES_DEF          = 5;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int SETTLE_CYCLES_DEF  = 4;
    localparam int CLR_CYCLES_DEF     = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ARM,
        S_RUN,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_e;

    // Majority decision: strictly more than half of the races won by path 1.
    function automatic logic majority(input logic [VOTE_W-1:0] ones, input int votes);
        return int'(ones) > (votes / 2);
    endfunction

endpackage

// File: rtl/ro_puf_sync2.sv
// Two-flop synchronizer carrying the race-done flag from the RO domain.
module ro_puf_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous flag; both stages clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequencer for the RO PUF: runs timed oscillator races per challenge,
// majority-votes the winners and returns a 4-bit response over valid/ready.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int VOTES          = VOTES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int CLR_CYCLES     = CLR_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] response,
    output logic              err,
    output logic              ro_en,
    output logic              ro_reset,
    output logic [CHAL_W-1:0] sel,
    input  logic [CNT_W-1:0]  count1,
    input  logic [CNT_W-1:0]  count2
);

    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PH_MAX0 = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int PH_MAX  = (PH_MAX0 > 2) ? PH_MAX0 : 2;
    localparam int PH_W    = $clog2(PH_MAX + 1);

    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT     = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [PH_W-1:0]  CLR_LAST    = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0]  ARM_LAST    = PH_W'(1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [VOTE_W-1:0]   vote_q, vote_d;
    logic [VOTE_W-1:0]   ones_q, ones_d;
    logic [RESP_W-1:0]   acc_q, acc_d;
    logic [RESP_W-1:0]   response_q, response_d;
    logic                err_q, err_d;
    logic                hit_q, hit_d;
    logic                ro_en_q;
    logic                ro_reset_q;

    logic                done_raw;
    logic                done_s;
    logic                win;
    logic [VOTE_W-1:0]   ones_n;
    logic [RESP_W-1:0]   acc_upd;

    // Either counter saturating marks the end of a race.
    assign done_raw = (&count1) | (&count2);

    ro_puf_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (done_raw),
        .q_o   (done_s)
    );

    // Next-state, phase timing, timeout and vote accumulation.
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        chal_d     = chal_q;
        vote_d     = vote_q;
        ones_d     = ones_q;
        acc_d      = acc_q;
        response_d = response_q;
        err_d      = err_q;
        win        = (count1 > count2);
        ones_n     = ones_q + VOTE_W'(win);
        acc_upd    = acc_q;
        acc_upd[chal_q] = majority(ones_n, VOTES);
        // A race is confirmed only after the synchronized flag holds two cycles.
        hit_d      = (state_q == S_RUN) ? done_s : 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    chal_d  = '0;
                    vote_d  = '0;
                    ones_d  = '0;
                    acc_d   = '0;
                end
            end
            S_CLR: begin
                if (ph_q == CLR_LAST) state_d = S_ARM;
            end
            S_ARM: begin
                if (ph_q == ARM_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (done_s && hit_q) begin
                    state_d = S_SETTLE;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d    = S_DONE;
                    err_d      = 1'b1;
                    response_d = '0;
                end
            end
            S_SETTLE: begin
                if (ph_q == SETTLE_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (int'(vote_q) + 1 < VOTES) begin
                    vote_d  = vote_q + VOTE_W'(1);
                    ones_d  = ones_n;
                    state_d = S_CLR;
                end else begin
                    vote_d = '0;
                    ones_d = '0;
                    acc_d  = acc_upd;
                    // Wraps to 0 after the last challenge so sel rests at 0.
                    chal_d = chal_q + CHAL_W'(1);
                    if (chal_q == CHAL_W'(RESP_W - 1)) begin
                        state_d    = S_DONE;
                        response_d = acc_upd;
                        err_d      = 1'b0;
                    end else begin
                        state_d = S_CLR;
                    end
                end
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ph_d = (state_d != state_q) ? '0 : ph_q + PH_W'(1);

        if (state_d == S_RUN && state_q != S_RUN) begin
            tmo_d = '0;
        end else if (state_q == S_RUN && tmo_q != TMO_SAT) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // State and datapath registers; RO controls are registered to stay glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            tmo_q      <= '0;
            chal_q     <= '0;
            vote_q     <= '0;
            ones_q     <= '0;
            acc_q      <= '0;
            response_q <= '0;
            err_q      <= 1'b0;
            hit_q      <= 1'b0;
            ro_en_q    <= 1'b0;
            ro_reset_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            tmo_q      <= tmo_d;
            chal_q     <= chal_d;
            vote_q     <= vote_d;
            ones_q     <= ones_d;
            acc_q      <= acc_d;
            response_q <= response_d;
            err_q      <= err_d;
            hit_q      <= hit_d;
            ro_en_q    <= (state_d == S_RUN);
            ro_reset_q <= (state_d == S_IDLE) || (state_d == S_CLR) || (state_d == S_DONE);
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign response   = response_q;
    assign err        = err_q;
    assign ro_en      = ro_en_q;
    assign ro_reset   = ro_reset_q;
    assign sel        = chal_q;

endmodule
